// File: rtl/din_debounce_pkg.sv
// Shared constants for the din_debounce input-conditioning block.
// Also holds a parameter legality helper used at elaboration time.
package din_debounce_pkg;

  localparam int DEB_CNT_W_DEFAULT = 16;
  localparam int DEB_CYC_DEFAULT   = 50000;
  localparam int DEB_SYNC_MIN      = 2;

  // True when the synchroniser depth and debounce length are usable for a counter of width cnt_w.
  function automatic bit deb_params_ok(int sync_stages, int cnt_w, int cyc);
    longint cnt_max;
    cnt_max = (longint'(1) << cnt_w) - 1;
    return (sync_stages >= DEB_SYNC_MIN) && (cnt_w >= 1) && (cyc >= 1) &&
           (longint'(cyc) <= cnt_max);
  endfunction

endpackage

// File: rtl/din_debounce_if.sv
// Signal bundle between the debouncer and its user.
// The master side drives the raw inputs and the count enable.
// The slave side is the debouncer itself.
// Optional macro DEBOUNCE_EDGE_EN adds the per-bit rise/fall strobes.
interface din_debounce_if
  import din_debounce_pkg::*;
#(
  parameter int BW = 1
);
  logic          ce;
  logic [BW-1:0] di_raw;
  logic [BW-1:0] do_stable;
  logic          changed;
`ifdef DEBOUNCE_EDGE_EN
  logic [BW-1:0] rise;
  logic [BW-1:0] fall;

  modport master (output ce, output di_raw,
                  input do_stable, input changed, input rise, input fall);
  modport slave  (input ce, input di_raw,
                  output do_stable, output changed, output rise, output fall);
`else
  modport master (output ce, output di_raw, input do_stable, input changed);
  modport slave  (input ce, input di_raw, output do_stable, output changed);
`endif
endinterface

// File: rtl/din_debounce_bit.sv
// One debounced bit: synchroniser chain, disagreement counter and stable flop.
// upd is combinational and high in the cycle before stable flips.
// The top level uses it to register the change strobes so that they line up with the new value.
module debounce_bit
  import din_debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = DEB_SYNC_MIN,
  parameter int CNT_W        = DEB_CNT_W_DEFAULT,
  parameter int DEBOUNCE_CYC = DEB_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic din,
  output logic stable,
  output logic upd
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;
  logic                   at_term;

  assign s       = sync[SYNC_STAGES-1];
  assign at_term = (cnt == TERM);
  assign upd     = (s != stable) && ce && at_term;

  // Synchronise din, count enabled cycles of disagreement and accept the new value at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      if (s == stable) begin
        cnt <= '0;
      end else if (ce) begin
        if (at_term) begin
          stable <= s;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/din_debounce.sv
// din_debounce: BW independent debounced inputs with a combined change strobe.
// Defining the macro DEBOUNCE_EDGE_EN adds registered per-bit rise/fall pulses.
// Those pulses coincide with changed.
module din_debounce
  import din_debounce_pkg::*;
#(
  parameter int BW           = 1,
  parameter int SYNC_STAGES  = DEB_SYNC_MIN,
  parameter int CNT_W        = DEB_CNT_W_DEFAULT,
  parameter int DEBOUNCE_CYC = DEB_CYC_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  din_debounce_if.slave  bus
);

  if (!deb_params_ok(SYNC_STAGES, CNT_W, DEBOUNCE_CYC)) begin : g_bad_params
    $error("din_debounce: illegal parameters SYNC_STAGES=%0d CNT_W=%0d DEBOUNCE_CYC=%0d",
           SYNC_STAGES, CNT_W, DEBOUNCE_CYC);
  end

  logic [BW-1:0] stable;
  logic [BW-1:0] upd;
  logic          changed_q;

  for (genvar i = 0; i < BW; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .CNT_W        (CNT_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .ce     (bus.ce),
      .din    (bus.di_raw[i]),
      .stable (stable[i]),
      .upd    (upd[i])
    );
  end

  // One pulse whenever any bit is about to update, aligned with the new stable value.
  always_ff @(posedge clk) begin
    if (rst) changed_q <= 1'b0;
    else     changed_q <= |upd;
  end

  assign bus.do_stable = stable;
  assign bus.changed   = changed_q;

`ifdef DEBOUNCE_EDGE_EN
  logic [BW-1:0] rise_q;
  logic [BW-1:0] fall_q;

  // Direction of each update comes from the value being replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= upd & ~stable;
      fall_q <= upd & stable;
    end
  end

  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
`endif

endmodule

// File: tb/tb_din_debounce.sv
// Bench for din_debounce with BW=2, SYNC_STAGES=2, DEBOUNCE_CYC=4, CNT_W=3.
// The behavioural model delays each raw sample by the synchroniser depth.
// It then counts enabled cycles of disagreement and flips a bit once that run reaches DEBOUNCE_CYC.
module tb_din_debounce;
  localparam int BW   = 2;
  localparam int SYNC = 2;
  localparam int CYC  = 4;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  din_debounce_if #(.BW(BW)) bus();

  din_debounce #(
    .BW(BW), .SYNC_STAGES(SYNC), .CNT_W(CW), .DEBOUNCE_CYC(CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] m_hist [SYNC];
  int            m_run  [BW];
  logic [BW-1:0] m_st, m_rise, m_fall;
  logic          m_chg;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [BW-1:0] s, nst, up;
    s   = m_hist[SYNC-1];
    nst = m_st;
    up  = '0;
    if (rst) begin
      for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
      for (int b = 0; b < BW; b++) m_run[b] = 0;
      m_st = '0; m_chg = 1'b0; m_rise = '0; m_fall = '0;
    end else begin
      for (int b = 0; b < BW; b++) begin
        if (s[b] == m_st[b]) m_run[b] = 0;
        else if (bus.ce) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == CYC) begin
            nst[b] = s[b];
            m_run[b] = 0;
            up[b] = 1'b1;
          end
        end
      end
      m_rise = up & ~m_st;
      m_fall = up & m_st;
      m_chg  = |up;
      m_st   = nst;
      for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = bus.di_raw;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("do_stable", 8'(bus.do_stable), 8'(m_st));
    chk("changed", 8'(bus.changed), 8'(m_chg));
`ifdef DEBOUNCE_EDGE_EN
    chk("rise", 8'(bus.rise), 8'(m_rise));
    chk("fall", 8'(bus.fall), 8'(m_fall));
`endif
  endtask

  initial begin
    int upd_k;
    for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
    for (int b = 0; b < BW; b++) m_run[b] = 0;
    m_st = '0; m_chg = 1'b0; m_rise = '0; m_fall = '0;

    // 1: reset with inputs high, then 6-edge latency to 11
    rst = 1'b1; bus.ce = 1'b1; bus.di_raw = 2'b11;
    repeat (3) begin
      tick();
      chk("t1_rst_stable", 8'(bus.do_stable), 8'h0);
      chk("t1_rst_changed", 8'(bus.changed), 8'h0);
    end
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("t1_hold", 8'(bus.do_stable), 8'h0);
    end
    tick();
    chk("t1_set", 8'(bus.do_stable), 8'h3);
    chk("t1_changed", 8'(bus.changed), 8'h1);
`ifdef DEBOUNCE_EDGE_EN
    chk("t1_rise", 8'(bus.rise), 8'h3);
`endif
    tick();
    chk("t1_changed_once", 8'(bus.changed), 8'h0);

    // 2: return to 00, then a 3-cycle glitch on bit 0 is rejected
    bus.di_raw = 2'b00;
    repeat (6) tick();
    chk("t2_pre", 8'(bus.do_stable), 8'h0);
    repeat (4) tick();
    bus.di_raw = 2'b01;
    repeat (3) tick();
    bus.di_raw = 2'b00;
    repeat (10) begin
      tick();
      chk("t2_stable", 8'(bus.do_stable), 8'h0);
      chk("t2_changed", 8'(bus.changed), 8'h0);
    end

    // 3: bit 1 step
    bus.di_raw = 2'b10;
    repeat (5) begin
      tick();
      chk("t3_hold", 8'(bus.do_stable), 8'h0);
    end
    tick();
    chk("t3_set", 8'(bus.do_stable), 8'h2);
`ifdef DEBOUNCE_EDGE_EN
    chk("t3_rise", 8'(bus.rise), 8'h2);
    chk("t3_fall", 8'(bus.fall), 8'h0);
`endif

    // 4: ce on every 4th cycle
    bus.di_raw = 2'b11;
    upd_k = -1;
    for (int k = 0; k < 20; k++) begin
      bus.ce = ((k % 4) == 3);
      tick();
      if (bus.do_stable[0] && upd_k < 0) upd_k = k;
    end
    bus.ce = 1'b1;
    chk("t4_update_cycle", 8'(upd_k), 8'd15);

    // 5: reset in the middle of a count
    rst = 1'b1; tick(); rst = 1'b0;
    bus.di_raw = 2'b00;
    repeat (2) tick();
    bus.di_raw = 2'b01;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_stable", 8'(bus.do_stable), 8'h0);
    chk("t5_rst_changed", 8'(bus.changed), 8'h0);
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("t5_hold", 8'(bus.do_stable), 8'h0);
    end
    tick();
    chk("t5_set", 8'(bus.do_stable), 8'h1);

    // 6: staggered steps give two separate changed pulses
    repeat (3) tick();
    bus.di_raw = 2'b00;
    for (int n = 1; n <= 10; n++) begin
      if (n == 3) bus.di_raw = 2'b10;
      tick();
      if (n == 5) chk("t6_before", 8'(bus.do_stable), 8'h1);
      if (n == 6) begin
        chk("t6_bit0", 8'(bus.do_stable), 8'h0);
        chk("t6_chg_a", 8'(bus.changed), 8'h1);
      end
      if (n == 7) chk("t6_gap", 8'(bus.changed), 8'h0);
      if (n == 8) begin
        chk("t6_bit1", 8'(bus.do_stable), 8'h2);
        chk("t6_chg_b", 8'(bus.changed), 8'h1);
      end
    end

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) bus.di_raw = 2'($urandom);
      bus.ce = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
